// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and defaults for the FIFO read-side stream adapter
package fifo_pkg;

  // Default data width; must agree with the SYNC_FIFO instance being drained.
  localparam int FIFO_DWIDTH = 8;

  typedef logic [FIFO_DWIDTH-1:0] word_t;

  // Output buffer occupancy, 0..2.
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_adapter_sva.sv
// rtl/fifo_stream_adapter_sva.sv - invariant checks bound into the stream adapter
module fifo_stream_adapter_sva import fifo_pkg::*; #(
  parameter int DWIDTH = FIFO_DWIDTH
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  input occ_t              occ,
  input logic              inflight,
  input logic              capture,
  input logic              m_valid,
  input logic              m_ready,
  input logic [DWIDTH-1:0] m_data
);

  // Never more than two words held plus in flight.
  a_outstanding: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, occ} + {2'b0, inflight}) <= 3'd2);

  // A landing word must always find a free slot.
  a_no_capture_full: assert property (@(posedge clk) disable iff (rst)
    capture |-> (occ != 2'd2));

  // Head word holds steady while downstream stalls.
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready && !flush) |=> $stable(m_data));

endmodule

bind fifo_stream_adapter fifo_stream_adapter_sva #(.DWIDTH(DWIDTH)) u_sva (
  .clk      (clk),
  .rst      (rst),
  .flush    (flush),
  .occ      (occ),
  .inflight (inflight),
  .capture  (capture),
  .m_valid  (m_valid),
  .m_ready  (m_ready),
  .m_data   (m_data)
);

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry circular buffer with push, pop and clear
module skid_buf2 import fifo_pkg::*; #(
  parameter int DWIDTH = FIFO_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output occ_t              occ,
  output logic [DWIDTH-1:0] head_data
);

  logic [DWIDTH-1:0] mem [2];
  logic              head;
  logic              tail;

  assign head_data = mem[head];

  // Pointer, occupancy and storage update; clear drops contents logically but keeps data bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= 1'b0;
      tail   <= 1'b0;
      occ    <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clear) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      occ <= occ + occ_t'(push) - occ_t'(pop);
    end
  end

endmodule

// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - drains a registered-read FIFO into a valid/ready stream
module fifo_stream_adapter import fifo_pkg::*; #(
  parameter int DWIDTH    = FIFO_DWIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DWIDTH-1:0]    fifo_rd_data,
  input  logic                 flush,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DWIDTH-1:0]    m_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] deliv_cnt
);

  occ_t       occ;
  logic       inflight;
  logic       drop;
  logic       pop;
  logic       capture;
  logic [2:0] outstanding;

  assign pop     = m_valid && m_ready;
  assign capture = inflight && !drop;
  assign m_valid = (occ != 2'd0);
  assign busy    = m_valid || inflight;

  // Words held or arriving after this cycle; pop implies occ >= 1 so this never underflows.
  assign outstanding = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  // Issue a read only when the buffer is guaranteed to have room when the word lands.
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (outstanding < 3'd2);

  skid_buf2 #(.DWIDTH(DWIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (capture),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  // Track the read in flight, mark it for discard across a flush, and count delivered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= 1'b0;
      drop      <= 1'b0;
      deliv_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      drop     <= flush && inflight;
      if (pop && !flush) begin
        deliv_cnt <= deliv_cnt + 1'b1;
      end
    end
  end

endmodule
